// File: rtl/uart_msr_ctrl_if.sv
// uart_msr_ctrl_if -- register/interrupt side of the modem-status controller.
//   MSR_RD  : single-cycle strobe, bus read of MSR (master -> slave)
//   IER_MS  : modem-status interrupt enable, IER bit 3 (master -> slave)
//   MSR     : {DCD, RI, DSR, CTS, DDCD, TERI, DDSR, DCTS} (slave -> master)
//   MSR_IRQ : modem-status interrupt request (slave -> master)
interface uart_msr_ctrl_if;
  logic       MSR_RD;
  logic       IER_MS;
  logic [7:0] MSR;
  logic       MSR_IRQ;

  modport master (
    output MSR_RD,
    output IER_MS,
    input  MSR,
    input  MSR_IRQ
  );

  modport slave (
    input  MSR_RD,
    input  IER_MS,
    output MSR,
    output MSR_IRQ
  );
endinterface

// File: rtl/uart_msr_ctrl.sv
// uart_msr_ctrl -- modem-status controller for the APB UART.
// Synchronises the active-low modem pads (or takes the MCR loopback bits),
// optionally glitch-filters them, and maintains the 16550 MSR with sticky
// delta bits that clear on read, plus the modem-status interrupt request.
//
// Optional feature macro: MSR_GLITCH_FILTER_EN
//   defined   : per-bit counter, status updates after FILT_CYCLES
//               consecutive differing cycles
//   undefined : status samples the raw value every cycle
//
// Ports:
//   CLK                      in  system clock, rising edge
//   RST                      in  asynchronous active-high reset
//   CTSN, DSRN, RIN, DCDN    in  asynchronous active-low modem pads
//   LOOP                     in  loopback enable (MCR bit 4)
//   LOOP_RTS/DTR/OUT1/OUT2   in  MCR bits used as sources in loopback
//   bus (slave modport)          MSR_RD, IER_MS in; MSR, MSR_IRQ out
module uart_msr_ctrl #(
  parameter int unsigned FILT_CYCLES = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           CTSN,
  input  logic           DSRN,
  input  logic           RIN,
  input  logic           DCDN,
  input  logic           LOOP,
  input  logic           LOOP_RTS,
  input  logic           LOOP_DTR,
  input  logic           LOOP_OUT1,
  input  logic           LOOP_OUT2,
  uart_msr_ctrl_if.slave bus
);

  if (FILT_CYCLES < 1 || FILT_CYCLES > 255) begin : g_filt_range_chk
    $error("uart_msr_ctrl: FILT_CYCLES must be in 1..255");
  end

  // Bit order for all 4-bit vectors: [3]=DCD, [2]=RI, [1]=DSR, [0]=CTS.
  logic [3:0] r_s1;
  logic [3:0] r_s2;
  logic [3:0] r_st;
  logic [3:0] r_delta;

  logic [3:0] w_pad;
  logic [3:0] w_raw;
  logic [3:0] w_st_next;
  logic [3:0] w_chg;
  logic [3:0] w_set;

  assign w_pad = {DCDN, RIN, DSRN, CTSN};
  assign w_raw = LOOP ? {LOOP_OUT2, LOOP_OUT1, LOOP_DTR, LOOP_RTS} : ~r_s2;

`ifdef MSR_GLITCH_FILTER_EN
  localparam logic [7:0] LP_LAST = 8'(FILT_CYCLES - 1);

  logic [7:0] r_cnt      [4];
  logic [7:0] w_cnt_next [4];

  // Counter holds the number of consecutive differing cycles already seen;
  // when it reaches FILT_CYCLES-1 the current cycle is the FILT_CYCLES-th.
  always_comb begin
    w_st_next = r_st;
    for (int unsigned i = 0; i < 4; i++) begin
      w_cnt_next[i] = '0;
      if (w_raw[i] != r_st[i]) begin
        if (r_cnt[i] == LP_LAST) begin
          w_st_next[i] = w_raw[i];
        end else begin
          w_cnt_next[i] = r_cnt[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end
`else
  assign w_st_next = w_raw;
`endif

  // TERI only on the trailing edge of ring indicate (RI 1->0).
  assign w_chg = w_st_next ^ r_st;
  assign w_set = {w_chg[3], w_chg[2] & r_st[2], w_chg[1], w_chg[0]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1    <= '1;
      r_s2    <= '1;
      r_st    <= '0;
      r_delta <= '0;
    end else begin
      r_s1    <= w_pad;
      r_s2    <= r_s1;
      r_st    <= w_st_next;
      // A new change at the read-clear edge still sets its delta.
      r_delta <= (bus.MSR_RD ? 4'b0000 : r_delta) | w_set;
    end
  end

  assign bus.MSR     = {r_st, r_delta};
  assign bus.MSR_IRQ = bus.IER_MS & (|r_delta);

endmodule

// File: tb/tb_uart_msr_ctrl.sv
// tb_uart_msr_ctrl -- directed self-checking bench for uart_msr_ctrl.
// Expected latency follows the build: FILT cycles with the glitch filter,
// one cycle without.
module tb_uart_msr_ctrl;

  localparam int unsigned FILT = 4;
`ifdef MSR_GLITCH_FILTER_EN
  localparam int unsigned L = FILT;
`else
  localparam int unsigned L = 1;
`endif

  logic CLK;
  logic RST;
  logic CTSN, DSRN, RIN, DCDN;
  logic LOOP, LOOP_RTS, LOOP_DTR, LOOP_OUT1, LOOP_OUT2;

  uart_msr_ctrl_if bus ();

  uart_msr_ctrl #(.FILT_CYCLES(FILT)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CTSN      (CTSN),
    .DSRN      (DSRN),
    .RIN       (RIN),
    .DCDN      (DCDN),
    .LOOP      (LOOP),
    .LOOP_RTS  (LOOP_RTS),
    .LOOP_DTR  (LOOP_DTR),
    .LOOP_OUT1 (LOOP_OUT1),
    .LOOP_OUT2 (LOOP_OUT2),
    .bus       (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic read_msr();
    bus.MSR_RD = 1'b1;
    tick(1);
    bus.MSR_RD = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    CTSN = 1'b1; DSRN = 1'b1; RIN = 1'b1; DCDN = 1'b1;
    LOOP = 1'b0; LOOP_RTS = 1'b0; LOOP_DTR = 1'b0; LOOP_OUT1 = 1'b0; LOOP_OUT2 = 1'b0;
    bus.MSR_RD = 1'b0;
    bus.IER_MS = 1'b0;

    // Reset state and idle hold.
    tick(2);
    check_val("rst_msr", bus.MSR, 8'h00);
    check_val("rst_irq", {7'b0, bus.MSR_IRQ}, 8'h00);
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check_val("idle_msr", bus.MSR, 8'h00);
    end

    // CTS assert: update exactly at edge 2+L.
    bus.IER_MS = 1'b1;
    CTSN = 1'b0;
    tick(2 + L - 1);
    check_val("cts_early", bus.MSR, 8'h00);
    tick(1);
    check_val("cts_msr", bus.MSR, 8'h11);
    check_val("cts_irq", {7'b0, bus.MSR_IRQ}, 8'h01);
    bus.MSR_RD = 1'b1;
    check_val("cts_rd_preclear", bus.MSR, 8'h11);
    tick(1);
    bus.MSR_RD = 1'b0;
    check_val("cts_after_rd", bus.MSR, 8'h10);
    check_val("cts_irq_clr", {7'b0, bus.MSR_IRQ}, 8'h00);

    // CTS deassert, clear.
    CTSN = 1'b1;
    tick(2 + L);
    check_val("cts_off", bus.MSR, 8'h01);
    read_msr();
    check_val("cts_off_rd", bus.MSR, 8'h00);

    // RI low 10 cycles: no TERI on the leading edge, TERI on the trailing.
    RIN = 1'b0;
    tick(2 + L);
    check_val("ri_on", bus.MSR, 8'h40);
    check_val("ri_on_irq", {7'b0, bus.MSR_IRQ}, 8'h00);
    tick(10 - (2 + L));
    RIN = 1'b1;
    tick(2 + L - 1);
    check_val("ri_hold", bus.MSR, 8'h40);
    tick(1);
    check_val("ri_teri", bus.MSR, 8'h04);
    check_val("ri_teri_irq", {7'b0, bus.MSR_IRQ}, 8'h01);
    read_msr();
    check_val("ri_rd", bus.MSR, 8'h00);

    // DSR 3-cycle pulse: filtered out only with the glitch filter.
    DSRN = 1'b0;
    tick(3);
    DSRN = 1'b1;
    tick(10);
`ifdef MSR_GLITCH_FILTER_EN
    check_val("dsr_glitch3", bus.MSR, 8'h00);
`else
    check_val("dsr_glitch3", bus.MSR, 8'h02);
`endif
    read_msr();
    check_val("dsr_glitch3_rd", bus.MSR, 8'h00);
    // 4-cycle pulse passes in both builds.
    DSRN = 1'b0;
    tick(4);
    DSRN = 1'b1;
    tick(12);
    check_val("dsr_pulse4", bus.MSR, 8'h02);
    read_msr();
    check_val("dsr_pulse4_rd", bus.MSR, 8'h00);

    // Loopback: set DCTS, then DCD update coinciding with the read clear.
    bus.IER_MS = 1'b0;
    LOOP = 1'b1;
    tick(L + 3);
    check_val("loop_quiet", bus.MSR, 8'h00);
    LOOP_RTS = 1'b1;
    tick(L);
    check_val("loop_cts", bus.MSR, 8'h11);
    check_val("loop_irq_off", {7'b0, bus.MSR_IRQ}, 8'h00);
    LOOP_OUT2 = 1'b1;
    tick(L - 1);
    bus.MSR_RD = 1'b1;
    check_val("loop_rd_preclear", bus.MSR, 8'h11);
    tick(1);
    bus.MSR_RD = 1'b0;
    check_val("loop_set_wins", bus.MSR, 8'h98);
    check_val("loop_irq_dis", {7'b0, bus.MSR_IRQ}, 8'h00);
    bus.IER_MS = 1'b1;
    #1;
    check_val("loop_irq_en", {7'b0, bus.MSR_IRQ}, 8'h01);

    // DCD pad change aborted by reset after edge 2, then full re-acquire.
    DCDN = 1'b0;
    tick(2);
    RST = 1'b1;
    #1;
    check_val("rst_mid_msr", bus.MSR, 8'h00);
    check_val("rst_mid_irq", {7'b0, bus.MSR_IRQ}, 8'h00);
    LOOP = 1'b0;
    LOOP_RTS = 1'b0;
    LOOP_OUT2 = 1'b0;
    tick(1);
    RST = 1'b0;
    tick(2 + L - 1);
    check_val("dcd_reacq_early", bus.MSR, 8'h00);
    tick(1);
    check_val("dcd_reacq", bus.MSR, 8'h88);
    check_val("dcd_reacq_irq", {7'b0, bus.MSR_IRQ}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
